// File: rtl/payload_scan_ctrl.sv
// Payload scan controller: sequences one packet at a time through a bank of
// sticky matching engines, then summarises the bank into a single result
// (hit flag, lowest matching rule, match count, scanned length, truncation).
module payload_scan_ctrl #(
  parameter int NUM_ENGINES = 128,
  parameter int DRAIN_CYC   = 2,
  parameter int LEN_W       = 16,
  localparam int RULE_W     = $clog2(NUM_ENGINES),
  localparam int CNT_W      = $clog2(NUM_ENGINES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_byte,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   s_eop,
  output logic                   s_ready,
  output logic [7:0]             eng_byte,
  output logic                   eng_byte_vld,
  output logic                   eng_en,
  output logic                   eng_sod,
  input  logic [NUM_ENGINES-1:0] eng_match,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_hit,
  output logic [RULE_W-1:0]      res_rule,
  output logic [CNT_W-1:0]       res_cnt,
  output logic [LEN_W-1:0]       res_len,
  output logic                   res_trunc,
  output logic [15:0]            drop_cnt
);

  localparam int DC_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOD   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CAPT  = 3'd4,
    ST_RES   = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              s_ready_s;
  logic              scan_acc_s;
  logic              trunc_set_s;
  logic [LEN_W-1:0]  len_r;
  logic              trunc_r;
  logic [DC_W-1:0]   drain_cnt_r;
  logic              sod_r;
  logic [7:0]        eng_byte_r;
  logic              eng_byte_vld_r;
  logic              eng_en_r;
  logic              res_valid_r;
  logic              res_hit_r;
  logic [RULE_W-1:0] res_rule_r;
  logic [CNT_W-1:0]  res_cnt_r;
  logic [LEN_W-1:0]  res_len_r;
  logic              res_trunc_r;
  logic [15:0]       drop_cnt_r;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [RULE_W-1:0] lowest_idx(input logic [NUM_ENGINES-1:0] m);
    logic [RULE_W-1:0] idx;
    idx = {RULE_W{1'b0}};
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (m[i]) idx = RULE_W'(i);
    end
    return idx;
  endfunction

  // Number of set bits.
  function automatic logic [CNT_W-1:0] pop_count(input logic [NUM_ENGINES-1:0] m);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_ENGINES; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, m[i]};
    end
    return cnt;
  endfunction

  // A new sop arriving mid-packet closes the current one; the sop byte is left pending.
  assign trunc_set_s = (state_r == ST_SCAN) && s_valid && s_sop && (len_r != {LEN_W{1'b0}});
  assign scan_acc_s  = (state_r == ST_SCAN) && s_valid && s_ready_s;

  // Next-state and input back-pressure.
  always_comb begin
    state_nxt_s = state_r;
    s_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_ready_s = ~s_sop;
        if (s_valid && s_sop) state_nxt_s = ST_SOD;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_SOD: begin
        state_nxt_s = ST_SCAN;
      end
      ST_SCAN: begin
        if (trunc_set_s) begin
          s_ready_s   = 1'b0;
          state_nxt_s = ST_DRAIN;
        end else begin
          s_ready_s = 1'b1;
          if (s_valid && s_eop) state_nxt_s = ST_DRAIN;
          else                  state_nxt_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == {DC_W{1'b0}}) state_nxt_s = ST_CAPT;
        else                             state_nxt_s = ST_DRAIN;
      end
      ST_CAPT: begin
        state_nxt_s = ST_RES;
      end
      ST_RES: begin
        if (res_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RES;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Engine-side drive: byte and enables are registered, so engines see a byte one cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_byte_r     <= 8'd0;
      eng_byte_vld_r <= 1'b0;
      eng_en_r       <= 1'b0;
      sod_r          <= 1'b0;
    end else begin
      if (scan_acc_s) eng_byte_r <= s_byte;
      else            eng_byte_r <= eng_byte_r;
      eng_byte_vld_r <= scan_acc_s;
      eng_en_r       <= scan_acc_s || (state_r == ST_DRAIN);
      sod_r          <= (state_nxt_s == ST_SOD);
    end
  end

  // Per-packet length, truncation flag and drain down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r       <= {LEN_W{1'b0}};
      trunc_r     <= 1'b0;
      drain_cnt_r <= {DC_W{1'b0}};
    end else begin
      if (state_r == ST_SOD)                             len_r <= {LEN_W{1'b0}};
      else if (scan_acc_s && (len_r != {LEN_W{1'b1}}))   len_r <= len_r + LEN_W'(1'b1);
      else                                               len_r <= len_r;
      if (state_r == ST_SOD)   trunc_r <= 1'b0;
      else if (trunc_set_s)    trunc_r <= 1'b1;
      else                     trunc_r <= trunc_r;
      if (state_r != ST_DRAIN)                   drain_cnt_r <= DC_W'(DRAIN_CYC - 1);
      else if (drain_cnt_r != {DC_W{1'b0}})      drain_cnt_r <= drain_cnt_r - DC_W'(1'b1);
      else                                       drain_cnt_r <= drain_cnt_r;
    end
  end

  // Saturating count of stray non-sop bytes discarded while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && s_valid && !s_sop && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // Capture the engine bank summary once the drain completes; held until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_hit_r   <= 1'b0;
      res_rule_r  <= {RULE_W{1'b0}};
      res_cnt_r   <= {CNT_W{1'b0}};
      res_len_r   <= {LEN_W{1'b0}};
      res_trunc_r <= 1'b0;
    end else begin
      res_valid_r <= (state_nxt_s == ST_RES);
      if (state_r == ST_CAPT) begin
        res_hit_r   <= |eng_match;
        res_rule_r  <= lowest_idx(eng_match);
        res_cnt_r   <= pop_count(eng_match);
        res_len_r   <= len_r;
        res_trunc_r <= trunc_r;
      end else begin
        res_hit_r   <= res_hit_r;
        res_rule_r  <= res_rule_r;
        res_cnt_r   <= res_cnt_r;
        res_len_r   <= res_len_r;
        res_trunc_r <= res_trunc_r;
      end
    end
  end

  assign s_ready      = s_ready_s & ~rst;
  assign eng_sod      = rst | sod_r;
  assign eng_byte     = eng_byte_r;
  assign eng_byte_vld = eng_byte_vld_r;
  assign eng_en       = eng_en_r;
  assign res_valid    = res_valid_r;
  assign res_hit      = res_hit_r;
  assign res_rule     = res_rule_r;
  assign res_cnt      = res_cnt_r;
  assign res_len      = res_len_r;
  assign res_trunc    = res_trunc_r;
  assign drop_cnt     = drop_cnt_r;

endmodule
